pc_gen_stage: RTL and testbench

- Pre-IF stage. Owns the architectural next-fetch PC and presents it to the fetch stage through a valid/ready handshake.
- Applies redirects in priority order: reset vector, exception/ERET, branch/jump, sequential +4.
- Implements MIPS delay-slot ordering: a taken branch target is issued only after the branch's delay-slot PC has been issued.

---
 rtl/pc_gen_stage_pkg.sv | 21 ++
 rtl/pc_gen_stage.sv | 99 +++++++++
 tb/tb_pc_gen_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_stage_pkg.sv
// pc_gen_stage_pkg: shared constants and types for the pre-IF PC generator.
// The vector constants are also consumed by the CP0 logic.
package pc_gen_stage_pkg;

    // Boot ROM reset vector and general exception vector.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_RESET    = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_GENERAL  = 32'hBFC0_0380;

    // SEQ: sequential fetch. PEND: taken target buffered, delay slot not yet issued.
    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

    // Next sequential instruction address, 32-bit wrap-around.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_gen_stage.sv
// pc_gen_stage: pre-IF stage. Owns the next-fetch PC, offers it to fetch over
// a valid/ready handshake and applies redirects in priority order
// exception > ERET > branch/jump > sequential, honouring the MIPS delay slot.
// Optional macro PC_ISSUE_CNT_EN enables the issued-PC counter on issue_cnt_o;
// without it issue_cnt_o is tied to zero.
module pc_gen_stage
    import pc_gen_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        valid_o,
    output logic [31:0] pc_o,
    input  logic        ready_i,
    input  logic        br_fire_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_i,
    input  logic [31:0] exc_target_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic        squash_o,
    output logic [31:0] issue_cnt_o
);

    pc_state_e   state;
    logic [31:0] pend_target;
    logic        issue;
    logic [31:0] ds;
    logic [31:0] ds4;

    assign issue = valid_o & ready_i;
    // Delay-slot PC of the resolving branch, and the first PC after it.
    assign ds    = br_pc_i + 32'd4;
    assign ds4   = br_pc_i + 32'd8;

    // Redirect mux and SEQ/PEND state machine; pc_o only moves on issue or redirect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_o     <= 1'b0;
            pc_o        <= RESET_PC;
            squash_o    <= 1'b0;
            state       <= ST_SEQ;
            pend_target <= 32'd0;
        end else begin
            valid_o  <= 1'b1;
            squash_o <= 1'b0;
            if (exc_i) begin
                pc_o  <= exc_target_i;
                state <= ST_SEQ;
            end else if (eret_i) begin
                pc_o  <= epc_i;
                state <= ST_SEQ;
            end else if (br_fire_i && state == ST_SEQ) begin
                if (pc_o == ds) begin
                    // Delay slot is the PC currently offered: target must wait for it.
                    if (issue) begin
                        pc_o <= br_target_i;
                    end else begin
                        pend_target <= br_target_i;
                        state       <= ST_PEND;
                    end
                end else if (pc_o == ds4) begin
                    pc_o <= br_target_i;
                end else begin
                    // PCs beyond the delay slot already left; downstream must kill them.
                    pc_o     <= br_target_i;
                    squash_o <= 1'b1;
                end
            end else if (state == ST_PEND) begin
                if (issue) begin
                    pc_o  <= pend_target;
                    state <= ST_SEQ;
                end
            end else if (issue) begin
                pc_o <= pc_plus4(pc_o);
            end
        end
    end

`ifdef PC_ISSUE_CNT_EN
    logic [31:0] issue_cnt;

    // Free-running count of issued PCs, wraps naturally, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            issue_cnt <= 32'd0;
        end else if (issue) begin
            issue_cnt <= issue_cnt + 32'd1;
        end
    end

    assign issue_cnt_o = issue_cnt;
`else
    assign issue_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_gen_stage.sv
// tb_pc_gen_stage: directed plus randomized bench for pc_gen_stage against a
// behavioural model of the next-fetch PC rules.
module tb_pc_gen_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        ready_i;
    logic        br_fire_i;
    logic [31:0] br_pc_i;
    logic [31:0] br_target_i;
    logic        exc_i;
    logic [31:0] exc_target_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic        squash_o;
    logic [31:0] issue_cnt_o;

    int tests  = 0;
    int failed = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_sq;
    logic        m_pend;
    logic [31:0] m_buf;
    logic [31:0] m_cnt;
    logic [31:0] issued_q[$];

    always #5 clk = ~clk;

    pc_gen_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .ready_i     (ready_i),
        .br_fire_i   (br_fire_i),
        .br_pc_i     (br_pc_i),
        .br_target_i (br_target_i),
        .exc_i       (exc_i),
        .exc_target_i(exc_target_i),
        .eret_i      (eret_i),
        .epc_i       (epc_i),
        .squash_o    (squash_o),
        .issue_cnt_o (issue_cnt_o)
    );

    // Apply the fetch-PC rules to the model for the edge that just happened.
    task automatic model_step();
        logic iss;
        iss = m_valid && ready_i;
        if (!resetn) begin
            m_pc = 32'hBFC0_0000; m_valid = 0; m_sq = 0; m_pend = 0; m_buf = 0; m_cnt = 0;
            issued_q.delete();
        end else begin
            if (iss) begin
                m_cnt = m_cnt + 1;
                issued_q.push_back(m_pc);
            end
            m_valid = 1;
            m_sq = 0;
            if (exc_i) begin
                m_pc = exc_target_i; m_pend = 0;
            end else if (eret_i) begin
                m_pc = epc_i; m_pend = 0;
            end else if (br_fire_i && !m_pend) begin
                if (m_pc == br_pc_i + 4) begin
                    if (iss) m_pc = br_target_i;
                    else begin m_pend = 1; m_buf = br_target_i; end
                end else begin
                    m_sq = (m_pc != br_pc_i + 8);
                    m_pc = br_target_i;
                end
            end else if (m_pend) begin
                if (iss) begin m_pc = m_buf; m_pend = 0; end
            end else if (iss) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_cnt;
`ifdef PC_ISSUE_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        tests++;
        assert (pc_o === m_pc) else begin
            failed++; $error("FAIL pc: observed %h expected %h", pc_o, m_pc);
        end
        tests++;
        assert (valid_o === m_valid) else begin
            failed++; $error("FAIL valid: observed %b expected %b", valid_o, m_valid);
        end
        tests++;
        assert (squash_o === m_sq) else begin
            failed++; $error("FAIL squash: observed %b expected %b", squash_o, m_sq);
        end
        tests++;
        assert (issue_cnt_o === exp_cnt) else begin
            failed++; $error("FAIL issue_cnt: observed %0d expected %0d", issue_cnt_o, exp_cnt);
        end
    endtask

    // One clock: advance model at the edge, compare 1 ns later, drop pulses.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        br_fire_i = 0; exc_i = 0; eret_i = 0;
    endtask

    task automatic expect_pc(input string tag, input logic [31:0] exp);
        tests++;
        assert (pc_o === exp) else begin
            failed++; $error("FAIL %s: observed pc %h expected %h", tag, pc_o, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++; $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_eret(input logic [31:0] epc);
        eret_i = 1; epc_i = epc; cycle();
    endtask

    task automatic do_br(input logic [31:0] bpc, input logic [31:0] tgt);
        br_fire_i = 1; br_pc_i = bpc; br_target_i = tgt; cycle();
    endtask

    initial begin
        logic [31:0] exp_cnt;
        resetn = 0; ready_i = 1; br_fire_i = 0; br_pc_i = 0; br_target_i = 0;
        exc_i = 0; exc_target_i = 0; eret_i = 0; epc_i = 0;
        m_pc = 0; m_valid = 0; m_sq = 0; m_pend = 0; m_buf = 0; m_cnt = 0;

        // Reset and sequential run
        repeat (3) cycle();
        expect_bit("reset_valid", valid_o, 1'b0);
        expect_pc("reset_pc", 32'hBFC0_0000);
        #3 resetn = 1;
        cycle(); expect_pc("seq0", 32'hBFC0_0000); expect_bit("valid_up", valid_o, 1'b1);
        cycle(); expect_pc("seq1", 32'hBFC0_0004);
        cycle(); expect_pc("seq2", 32'hBFC0_0008);
        cycle(); cycle(); expect_pc("seq4", 32'hBFC0_0010);

        // Branch while delay slot is stalled -> PEND
        ready_i = 0; cycle();
        do_br(32'hBFC0_000C, 32'hBFC0_0100); expect_pc("pend_hold", 32'hBFC0_0010);
        cycle(); expect_pc("pend_hold2", 32'hBFC0_0010);
        ready_i = 1; cycle(); expect_pc("pend_release", 32'hBFC0_0100);
        tests++;
        assert (issued_q.size() > 0 && issued_q[$] === 32'hBFC0_0010) else begin
            failed++; $error("FAIL ds_issued: last issued %h expected %h",
                             issued_q.size() > 0 ? issued_q[$] : 32'h0, 32'hBFC0_0010);
        end

        // Branch resolved after delay slot / after wrong path
        ready_i = 0;
        do_eret(32'hBFC0_0014);
        do_br(32'hBFC0_000C, 32'hBFC0_0200);
        expect_pc("br_ds4", 32'hBFC0_0200); expect_bit("br_ds4_sq", squash_o, 1'b0);
        do_eret(32'hBFC0_0018);
        do_br(32'hBFC0_000C, 32'hBFC0_0200);
        expect_pc("br_late", 32'hBFC0_0200); expect_bit("br_late_sq", squash_o, 1'b1);
        cycle(); expect_bit("sq_one_cycle", squash_o, 1'b0);

        // Exception drops a pending target; exc beats eret
        do_eret(32'hBFC0_0010);
        do_br(32'hBFC0_000C, 32'hBFC0_0300);
        ready_i = 1; exc_i = 1; exc_target_i = 32'hBFC0_0380; cycle();
        expect_pc("exc_in_pend", 32'hBFC0_0380);
        cycle(); expect_pc("exc_no_pend", 32'hBFC0_0384);
        exc_i = 1; eret_i = 1; epc_i = 32'h8000_1000; cycle();
        expect_pc("exc_over_eret", 32'hBFC0_0380);

        // Wrap-around and misaligned hold
        do_eret(32'hFFFF_FFFC);
        cycle(); expect_pc("wrap", 32'h0000_0000);
        ready_i = 0;
        do_eret(32'h8000_0002);
        repeat (4) cycle();
        expect_pc("misalign_hold", 32'h8000_0002);
        exc_i = 1; exc_target_i = 32'hBFC0_0380; cycle();
        expect_pc("hold_exc", 32'hBFC0_0380);

        // Issue counter: five issues after reset
        resetn = 0; ready_i = 1; cycle(); cycle();
        resetn = 1;
        repeat (6) cycle();
`ifdef PC_ISSUE_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        tests++;
        assert (issue_cnt_o === exp_cnt) else begin
            failed++; $error("FAIL cnt5: observed %0d expected %0d", issue_cnt_o, exp_cnt);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            ready_i = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 3) begin
                exc_i = 1; exc_target_i = $urandom;
                eret_i = ($urandom_range(0, 1) == 1); epc_i = $urandom;
            end else if (r < 7) begin
                eret_i = 1; epc_i = $urandom;
                if ($urandom_range(0, 1) == 1) epc_i[1:0] = 2'b00;
            end else if (r < 20 && !m_pend) begin
                br_fire_i = 1;
                br_pc_i = m_pc - 32'(4 * $urandom_range(1, 4));
                br_target_i = {$urandom} & 32'hFFFF_FFFC;
            end
            resetn = ($urandom_range(0, 199) != 0);
            cycle();
        end
        resetn = 1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
